// File: rtl/gpio_arb_pkg.sv
// Shared types and widths for the two-requester gpio port arbiter.
package gpio_arb_pkg;

  localparam int unsigned TIMEOUT_W = 8;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_c,
  output logic valid_c
);

  // Combinational winner selection
  always_comb begin
    valid_c = req0 | req1;
    grant_c = 1'b0;
    if (req0 && req1) begin
      grant_c = ~last_grant;
    end else if (req1) begin
      grant_c = 1'b1;
    end
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Shares one gpio peripheral port between two requesters: round-robin grant,
// one transaction in flight, optional per-transaction timeout.
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned size_addr = 1,
  parameter int unsigned timeout   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [size_addr-1:0] m0_address,
  input  logic [DATA_W-1:0]    m0_data_in,
  output logic [DATA_W-1:0]    m0_data_out,
  output logic                 m0_ready_r,
  output logic                 m0_ready_w,
  output logic                 m0_error,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [size_addr-1:0] m1_address,
  input  logic [DATA_W-1:0]    m1_data_in,
  output logic [DATA_W-1:0]    m1_data_out,
  output logic                 m1_ready_r,
  output logic                 m1_ready_w,
  output logic                 m1_error,
  output logic                 p_read,
  output logic                 p_write,
  output logic [size_addr-1:0] p_address,
  output logic [DATA_W-1:0]    p_data_w,
  input  logic [DATA_W-1:0]    p_data_r,
  input  logic                 p_ready_r,
  input  logic                 p_ready_w
);

  localparam logic                 TO_EN   = (timeout != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(timeout - 1);

  state_t                 state;
  op_t                    op;
  logic                   gnt;
  logic                   last_grant;
  logic [TIMEOUT_W-1:0]   cnt;
  logic [1:0]             rdy_r;
  logic [1:0]             rdy_w;
  logic [1:0]             err;
  logic [1:0][DATA_W-1:0] dout;

  logic                   pick_c;
  logic                   pick_valid_c;
  logic                   sel_write_c;
  logic [size_addr-1:0]   sel_addr_c;
  logic [DATA_W-1:0]      sel_data_c;
  logic                   match_c;

  rr_arbiter2 u_rr (
    .req0       (m0_read | m0_write),
    .req1       (m1_read | m1_write),
    .last_grant (last_grant),
    .grant_c    (pick_c),
    .valid_c    (pick_valid_c)
  );

  // Route the picked requester's payload and detect the matching peripheral done
  always_comb begin
    sel_write_c = pick_c ? m1_write   : m0_write;
    sel_addr_c  = pick_c ? m1_address : m0_address;
    sel_data_c  = pick_c ? m1_data_in : m0_data_in;
    match_c     = (op == OP_WRITE) ? p_ready_w : p_ready_r;
  end

  // Transaction FSM with latched request and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      op         <= OP_READ;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rdy_r      <= '0;
      rdy_w      <= '0;
      err        <= '0;
      dout       <= '0;
      p_read     <= 1'b0;
      p_write    <= 1'b0;
      p_address  <= '0;
      p_data_w   <= '0;
    end else begin
      p_read  <= 1'b0;
      p_write <= 1'b0;
      rdy_r   <= '0;
      rdy_w   <= '0;
      err     <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_valid_c) begin
            gnt       <= pick_c;
            op        <= sel_write_c ? OP_WRITE : OP_READ;
            p_address <= sel_addr_c;
            p_data_w  <= sel_data_c;
            p_write   <= sel_write_c;
            p_read    <= ~sel_write_c;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (match_c) begin
            if (op == OP_WRITE) begin
              rdy_w[gnt] <= 1'b1;
            end else begin
              rdy_r[gnt] <= 1'b1;
              dout[gnt]  <= p_data_r;
            end
            state <= DONE;
          end else if (TO_EN && (cnt == TO_LAST)) begin
            if (op == OP_WRITE) begin
              rdy_w[gnt] <= 1'b1;
            end else begin
              rdy_r[gnt] <= 1'b1;
            end
            err[gnt] <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        DONE: begin
          last_grant <= gnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_ready_r  = rdy_r[0];
  assign m0_ready_w  = rdy_w[0];
  assign m0_error    = err[0];
  assign m0_data_out = dout[0];
  assign m1_ready_r  = rdy_r[1];
  assign m1_ready_w  = rdy_w[1];
  assign m1_error    = err[1];
  assign m1_data_out = dout[1];

endmodule
